// File: rtl/conv_pkg.sv
// Shared types, tap numbering and rounding helpers for the 3x3 streaming convolver.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    // Tap index = ky*3 + kx, ky=0 is the top row, kx=0 the left column.
    localparam int TAP_TL   = 0;
    localparam int TAP_TC   = 1;
    localparam int TAP_TR   = 2;
    localparam int TAP_ML   = 3;
    localparam int TAP_MC   = 4;
    localparam int TAP_MR   = 5;
    localparam int TAP_BL   = 6;
    localparam int TAP_BC   = 7;
    localparam int TAP_BR   = 8;
    localparam int TAP_BIAS = 9;
    localparam int NUM_TAPS = 9;

    // Bits needed to count 0..n inclusive.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Round half-up, drop the fraction, saturate to a data_w-bit signed range,
    // optionally clamp negatives to zero. Result is sign-extended to 32 bits.
    function automatic logic [31:0] sat_round(input logic signed [63:0] acc,
                                              input int frac_w,
                                              input int data_w,
                                              input logic relu);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (r > hi)      r = hi;
        else if (r < lo) r = lo;
        if (relu && (r < 64'sd0)) r = 64'sd0;
        return r[31:0];
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two row memories plus a 2-column window register; the third window column is
// the incoming column, so the window presented is the one completed by this step.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_W = 11,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int RW     = cnt_w(IMG_H),
    parameter int CW     = cnt_w(IMG_W)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               shift,
    input  logic [DATA_W-1:0]                  pix,
    input  logic [RW-1:0]                      sr,
    input  logic [CW-1:0]                      sc,
    output logic [NUM_TAPS-1:0][DATA_W-1:0]    win,
    output logic [NUM_TAPS-1:0]                mask
);

    localparam logic [RW-1:0] ROW_END = RW'(IMG_H);
    localparam logic [RW-1:0] ROW_TWO = RW'(2);
    localparam logic [CW-1:0] COL_END = CW'(IMG_W);
    localparam logic [CW-1:0] COL_TWO = CW'(2);

    logic [DATA_W-1:0] lb_top [IMG_W];   // row sr-2
    logic [DATA_W-1:0] lb_mid [IMG_W];   // row sr-1

    logic [2:0][DATA_W-1:0] col0;        // column sc-2, index 0 = top row
    logic [2:0][DATA_W-1:0] col1;        // column sc-1
    logic [2:0][DATA_W-1:0] col_new;     // column sc
    logic                   in_col;
    logic [2:0]             row_ok;
    logic [2:0]             col_ok;

    assign in_col = (sc < COL_END);

    // Build the incoming column; the padding column and padding row are zero.
    always_comb begin
        col_new = '0;
        if (in_col) begin
            col_new[0] = lb_top[sc];
            col_new[1] = lb_mid[sc];
            col_new[2] = (sr < ROW_END) ? pix : '0;
        end
    end

    // Roll the row memories at the current column (storage only, no reset needed).
    always_ff @(posedge clk) begin
        if (shift && in_col) begin
            lb_top[sc] <= lb_mid[sc];
            lb_mid[sc] <= col_new[2];
        end
    end

    // Shift the window columns left by one on every scan step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col0 <= '0;
            col1 <= '0;
        end else if (shift) begin
            col0 <= col1;
            col1 <= col_new;
        end
    end

    // Present the window and mark taps that fall inside the image (centre = sr-1, sc-1).
    always_comb begin
        row_ok = {sr < ROW_END, 1'b1, sr >= ROW_TWO};
        col_ok = {sc < COL_END, 1'b1, sc >= COL_TWO};
        win    = '0;
        mask   = '0;
        for (int ky = 0; ky < 3; ky++) begin
            win[ky*3 + 0]  = col0[ky];
            win[ky*3 + 1]  = col1[ky];
            win[ky*3 + 2]  = col_new[ky];
            for (int kx = 0; kx < 3; kx++)
                mask[ky*3 + kx] = row_ok[ky] & col_ok[kx];
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 "same" convolution, NUM_FILT filters in parallel, one pixel per
// handshake; padding is injected internally from the scan counters.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int DATA_W   = 11,
    parameter int FRAC_W   = 10,
    parameter int IMG_W    = 28,
    parameter int IMG_H    = 28,
    parameter int NUM_FILT = 4,
    parameter int ACC_W    = 2*DATA_W + 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          w_we,
    input  logic [$clog2(NUM_FILT)-1:0]   w_filt,
    input  logic [3:0]                    w_tap,
    input  logic [DATA_W-1:0]             w_data,
    input  logic                          relu_en,
    input  logic                          start,
    input  logic                          pix_valid,
    output logic                          pix_ready,
    input  logic [DATA_W-1:0]             pix_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_FILT*DATA_W-1:0]    out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done
);

    localparam int RW = cnt_w(IMG_H);
    localparam int CW = cnt_w(IMG_W);
    localparam logic [RW-1:0] ROW_END = RW'(IMG_H);
    localparam logic [RW-1:0] ROW_PRE = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE = RW'(1);
    localparam logic [CW-1:0] COL_END = CW'(IMG_W);
    localparam int PW = 2*DATA_W;

    state_t state, state_nx;

    logic [RW-1:0] sr;
    logic [CW-1:0] sc;
    logic          scan_fin;
    logic          relu_q;

    logic [NUM_FILT-1:0][NUM_TAPS:0][DATA_W-1:0] wt;   // taps 0..8, bias at TAP_BIAS

    logic stall, consume, step, emit, out_hs;
    logic [NUM_TAPS-1:0][DATA_W-1:0] win;
    logic [NUM_TAPS-1:0]             mask;
    logic [NUM_FILT-1:0][DATA_W-1:0] res;

    assign stall   = out_valid && !out_ready;
    assign consume = (sr < ROW_END) && (sc < COL_END);
    assign out_hs  = out_valid && out_ready;
    assign emit    = step && (sr != '0) && (sc != '0);

    conv_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .RW     (RW),
        .CW     (CW)
    ) u_lb (
        .clk   (clk),
        .rst_n (rst_n),
        .shift (step),
        .pix   (pix_data),
        .sr    (sr),
        .sc    (sc),
        .win   (win),
        .mask  (mask)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state: fill the first row, run to the last image row, flush the padding row.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FILL;
            FILL:    if (step && sr == ROW_ONE && sc == '0) state_nx = RUN;
            RUN:     if (step && sr == ROW_PRE && sc == COL_END) state_nx = FLUSH;
            FLUSH:   if (out_hs && out_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs of the FSM: busy flag, input ready and scan-advance enable.
    always_comb begin
        busy      = (state != IDLE);
        pix_ready = ((state == FILL) || (state == RUN)) && consume && !stall;
        step      = (state != IDLE) && !scan_fin && !stall && (!consume || pix_valid);
    end

    // Scan position counters; relu mode is latched for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr       <= '0;
            sc       <= '0;
            scan_fin <= 1'b0;
            relu_q   <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                sr       <= '0;
                sc       <= '0;
                scan_fin <= 1'b0;
                relu_q   <= relu_en;
            end
        end else if (step) begin
            if (sc == COL_END) begin
                sc <= '0;
                if (sr == ROW_END) scan_fin <= 1'b1;
                else               sr       <= sr + 1'b1;
            end else begin
                sc <= sc + 1'b1;
            end
        end
    end

    // Weight/bias file, writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wt <= '0;
        end else if (state == IDLE && w_we && w_tap <= 4'd9 && int'(w_filt) < NUM_FILT) begin
            wt[w_filt][w_tap] <= w_data;
        end
    end

    // Per-filter multiply-accumulate over the masked window, then round/saturate.
    for (genvar f = 0; f < NUM_FILT; f++) begin : g_filt
        logic signed [ACC_W-1:0] acc;
        logic signed [PW-1:0]    prod;
        logic [31:0]             r32;
        logic                    unused_hi;

        always_comb begin
            prod = '0;
            acc  = {{(ACC_W-DATA_W-FRAC_W){wt[f][TAP_BIAS][DATA_W-1]}},
                    wt[f][TAP_BIAS], {FRAC_W{1'b0}}};
            for (int t = 0; t < NUM_TAPS; t++) begin
                prod = PW'($signed(win[t])) * PW'($signed(wt[f][t]));
                if (!mask[t]) prod = '0;
                acc = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
            end
            r32 = sat_round({{(64-ACC_W){acc[ACC_W-1]}}, acc}, FRAC_W, DATA_W, relu_q);
        end

        assign res[f]    = r32[DATA_W-1:0];
        assign unused_hi = ^r32[31:DATA_W];
    end

    // Output register: load on each window-completing step, hold while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == FLUSH) && out_hs && out_last;
            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= res;
                out_last  <= (sr == ROW_END) && (sc == COL_END);
            end else if (out_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream: a behavioural model fills a queue of
// expected outputs per frame; the monitor pops and compares on each handshake.
module tb_conv3x3_stream;

    localparam int DATA_W   = 11;
    localparam int FRAC_W   = 10;
    localparam int IMG_W    = 28;
    localparam int IMG_H    = 28;
    localparam int NUM_FILT = 4;
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int OW       = NUM_FILT * DATA_W;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        w_we = 1'b0;
    logic [$clog2(NUM_FILT)-1:0] w_filt = '0;
    logic [3:0]                  w_tap = '0;
    logic [DATA_W-1:0]           w_data = '0;
    logic                        relu_en = 1'b0;
    logic                        start = 1'b0;
    logic                        pix_valid = 1'b0;
    logic                        pix_ready;
    logic [DATA_W-1:0]           pix_data = '0;
    logic                        out_valid;
    logic                        out_ready = 1'b1;
    logic [OW-1:0]               out_data;
    logic                        out_last;
    logic                        busy;
    logic                        done;

    conv3x3_stream #(
        .DATA_W(DATA_W), .FRAC_W(FRAC_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_FILT(NUM_FILT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .w_we(w_we), .w_filt(w_filt), .w_tap(w_tap),
        .w_data(w_data), .relu_en(relu_en), .start(start), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_data(pix_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] d;
        bit            last;
    } exp_t;

    int   tests = 0;
    int   fails = 0;
    int   img [IMG_H][IMG_W];
    int   wts [NUM_FILT][10];
    bit   relu = 1'b0;
    exp_t exp_q [$];
    int   got [NUM_FILT][NPIX];

    // Frame run options.
    int gap_pct    = 0;
    int stall_pct  = 0;
    int busy_wr_at = -1;
    int abort_at   = -1;
    bit sw_en      = 1'b0;
    int sw_f = 0, sw_t = 0, sw_d = 0;

    function automatic int model(int f, int r, int c);
        longint acc;
        longint res;
        acc = longint'(wts[f][9]) * (64'sd1 <<< FRAC_W);
        for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++) begin
                int rr, cc;
                rr = r + ky - 1;
                cc = c + kx - 1;
                if (rr >= 0 && rr < IMG_H && cc >= 0 && cc < IMG_W)
                    acc += longint'(wts[f][ky*3 + kx]) * longint'(img[rr][cc]);
            end
        res = (acc + (64'sd1 <<< (FRAC_W - 1))) >>> FRAC_W;
        if (res > 1023)  res = 1023;
        if (res < -1024) res = -1024;
        if (relu && res < 0) res = 0;
        return int'(res);
    endfunction

    task automatic fill_img(input int v);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) img[r][c] = v;
    endtask

    task automatic set_wts(input int w, input int b);
        for (int f = 0; f < NUM_FILT; f++) begin
            for (int t = 0; t < 9; t++) wts[f][t] = w;
            wts[f][9] = b;
        end
    endtask

    task automatic write_w(input int f, input int t, input int d);
        @(posedge clk); #1;
        w_we = 1'b1; w_filt = f[$clog2(NUM_FILT)-1:0]; w_tap = t[3:0]; w_data = d[DATA_W-1:0];
        @(posedge clk); #1;
        w_we = 1'b0;
    endtask

    task automatic load_all();
        for (int f = 0; f < NUM_FILT; f++)
            for (int t = 0; t < 10; t++) write_w(f, t, wts[f][t]);
    endtask

    // Drive one frame, scoreboard every output, check framing/stall rules.
    task automatic run_frame(input string name);
        int   idx = 0, cyc = 0, post = 0, outs = 0, mis = 0, first = -1;
        int   stall_bad = 0, ready_bad = 0, last_bad = 0, done_cnt = 0;
        bit   stalled_prev = 1'b0, done_seen = 1'b0, bw_done = 1'b0, aborted = 1'b0;
        logic [OW-1:0] hold_d, first_got, first_exp;
        bit   hold_l;
        exp_t e;
        if (sw_en) wts[sw_f][sw_t] = sw_d;
        exp_q.delete();
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                for (int f = 0; f < NUM_FILT; f++) e.d[f*DATA_W +: DATA_W] = DATA_W'(model(f, r, c));
                e.last = (r == IMG_H-1) && (c == IMG_W-1);
                exp_q.push_back(e);
            end
        @(posedge clk); #1;
        start = 1'b1; relu_en = relu;
        if (sw_en) begin
            w_we = 1'b1; w_filt = sw_f[$clog2(NUM_FILT)-1:0]; w_tap = sw_t[3:0]; w_data = sw_d[DATA_W-1:0];
        end
        while (post < 4 && cyc < 20000) begin
            @(posedge clk); #1;
            start = 1'b0; w_we = 1'b0;
            if (busy_wr_at >= 0 && idx >= busy_wr_at && !bw_done) begin
                w_we = 1'b1; w_filt = '0; w_tap = 4'd4; w_data = '0; bw_done = 1'b1;
            end
            pix_valid = (idx < NPIX) && ($urandom_range(99) >= gap_pct);
            pix_data  = (idx < NPIX) ? DATA_W'(img[idx / IMG_W][idx % IMG_W]) : '0;
            out_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            cyc++;
            if (stalled_prev && (!out_valid || out_data !== hold_d || out_last !== hold_l)) stall_bad++;
            if (out_valid && !out_ready && pix_ready) ready_bad++;
            stalled_prev = out_valid && !out_ready;
            hold_d = out_data; hold_l = out_last;
            if (pix_valid && pix_ready) idx++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    mis++;
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e.d) begin
                        mis++;
                        if (first < 0) begin first = outs; first_got = out_data; first_exp = e.d; end
                    end
                    if (out_last !== e.last) last_bad++;
                end
                if (outs < NPIX)
                    for (int f = 0; f < NUM_FILT; f++)
                        got[f][outs] = int'($signed(out_data[f*DATA_W +: DATA_W]));
                outs++;
            end
            if (done) begin done_cnt++; done_seen = 1'b1; end
            if (done_seen) post++;
            if (abort_at >= 0 && idx >= abort_at) begin aborted = 1'b1; break; end
        end
        pix_valid = 1'b0;
        out_ready = 1'b1;
        if (aborted) return;
        tests++;
        if (!done_seen) begin fails++; $display("FAIL %s timeout: no done after %0d cycles (required done)", name, cyc); end
        tests++;
        if (mis != 0) begin
            fails++;
            $display("FAIL %s data: %0d mismatches, first at output %0d got %h required %h", name, mis, first, first_got, first_exp);
        end
        tests++;
        if (outs != NPIX) begin fails++; $display("FAIL %s count: got %0d outputs, required %0d", name, outs, NPIX); end
        tests++;
        if (last_bad != 0) begin fails++; $display("FAIL %s out_last: %0d misplaced, required 0", name, last_bad); end
        tests++;
        if (done_cnt != 1) begin fails++; $display("FAIL %s done: %0d pulses, required 1", name, done_cnt); end
        tests++;
        if (stall_bad != 0 || ready_bad != 0) begin
            fails++;
            $display("FAIL %s stall: %0d output changes, %0d pix_ready-high while stalled, required 0/0", name, stall_bad, ready_bad);
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({pix_ready, out_valid, out_last, busy, done} !== 5'b0) begin
            fails++; $display("FAIL reset_flags: got %b required 00000", {pix_ready, out_valid, out_last, busy, done});
        end
        tests++;
        if (out_data !== '0) begin fails++; $display("FAIL reset_data: got %h required 0", out_data); end
    endtask

    task automatic test_uniform();
        fill_img(128); set_wts(512, 0); relu = 1'b0; load_all();
        gap_pct = 0; stall_pct = 0;
        run_frame("uniform");
        tests++;
        if (got[0][5*IMG_W+5] !== 576) begin fails++; $display("FAIL uniform_interior: got %0d required 576", got[0][5*IMG_W+5]); end
        tests++;
        if (got[0][0] !== 256) begin fails++; $display("FAIL uniform_corner00: got %0d required 256", got[0][0]); end
        tests++;
        if (got[2][5] !== 384) begin fails++; $display("FAIL uniform_edge05: got %0d required 384", got[2][5]); end
        tests++;
        if (got[3][NPIX-1] !== 256) begin fails++; $display("FAIL uniform_corner_br: got %0d required 256", got[3][NPIX-1]); end
    endtask

    task automatic test_tap_order();
        int nz0 = 0, nz1 = 0;
        fill_img(0); img[10][10] = 1000;
        set_wts(0, 0); wts[0][0] = 512; wts[1][8] = 512;
        load_all();
        run_frame("tap_order");
        for (int n = 0; n < NPIX; n++) begin
            if (got[0][n] != 0) nz0++;
            if (got[1][n] != 0) nz1++;
        end
        tests++;
        if (got[0][11*IMG_W+11] !== 500 || nz0 != 1) begin
            fails++; $display("FAIL tap0: (11,11)=%0d nonzero=%0d, required 500 and 1", got[0][11*IMG_W+11], nz0);
        end
        tests++;
        if (got[1][9*IMG_W+9] !== 500 || nz1 != 1) begin
            fails++; $display("FAIL tap8: (9,9)=%0d nonzero=%0d, required 500 and 1", got[1][9*IMG_W+9], nz1);
        end
    endtask

    task automatic test_saturation();
        int n100 = 0;
        fill_img(1023); set_wts(1023, 0); relu = 1'b0; load_all();
        run_frame("sat_pos");
        tests++;
        if (got[0][5*IMG_W+5] !== 1023) begin fails++; $display("FAIL sat_pos: got %0d required 1023", got[0][5*IMG_W+5]); end
        set_wts(-1024, 0); load_all();
        run_frame("sat_neg");
        tests++;
        if (got[1][5*IMG_W+5] !== -1024) begin fails++; $display("FAIL sat_neg: got %0d required -1024", got[1][5*IMG_W+5]); end
        relu = 1'b1;
        run_frame("relu");
        tests++;
        if (got[1][5*IMG_W+5] !== 0) begin fails++; $display("FAIL relu: got %0d required 0", got[1][5*IMG_W+5]); end
        relu = 1'b0;
        set_wts(0, 100); load_all();
        run_frame("bias");
        for (int f = 0; f < NUM_FILT; f++)
            for (int n = 0; n < NPIX; n++) if (got[f][n] == 100) n100++;
        tests++;
        if (n100 != NUM_FILT*NPIX) begin fails++; $display("FAIL bias: %0d outputs equal 100, required %0d", n100, NUM_FILT*NPIX); end
    endtask

    task automatic test_backpressure();
        fill_img(128); set_wts(512, 0); load_all();
        gap_pct = 30; stall_pct = 70;
        run_frame("backpressure");
        gap_pct = 0; stall_pct = 0;
        tests++;
        if (got[0][5*IMG_W+5] !== 576) begin fails++; $display("FAIL bp_interior: got %0d required 576", got[0][5*IMG_W+5]); end
    endtask

    task automatic test_reset_mid();
        abort_at = 300;
        run_frame("abort");
        abort_at = -1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({out_valid, busy, pix_ready, done} !== 4'b0) begin
            fails++; $display("FAIL reset_mid: got %b required 0000", {out_valid, busy, pix_ready, done});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        set_wts(0, 0);
        run_frame("cleared_weights");
        set_wts(512, 0); load_all();
        run_frame("after_reset");
        tests++;
        if (got[0][5*IMG_W+5] !== 576) begin fails++; $display("FAIL after_reset_interior: got %0d required 576", got[0][5*IMG_W+5]); end
    endtask

    task automatic test_busy_write();
        busy_wr_at = 400;
        run_frame("busy_write");
        busy_wr_at = -1;
        tests++;
        if (got[0][5*IMG_W+5] !== 576) begin fails++; $display("FAIL busy_write: got %0d required 576", got[0][5*IMG_W+5]); end
        sw_en = 1'b1; sw_f = 0; sw_t = 4; sw_d = 0;
        run_frame("idle_write");
        sw_en = 1'b0;
        tests++;
        if (got[0][5*IMG_W+5] !== 512 || got[1][5*IMG_W+5] !== 576) begin
            fails++; $display("FAIL idle_write: f0=%0d f1=%0d required 512 576", got[0][5*IMG_W+5], got[1][5*IMG_W+5]);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        #2 rst_n = 1'b1;
        test_uniform();
        test_tap_order();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_busy_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
